// File: rtl/prores_pkg.sv
// rtl/prores_pkg.sv - shared types and helpers for the bitstream packer
package prores_pkg;

  typedef enum logic {PK_RUN, PK_DRAIN} packer_state_t;

  localparam int WORD_BITS = 32;
  localparam int ACC_BITS  = 64;

  // Byte lanes fill from [3] (first byte) downwards.
  function automatic logic [3:0] lanes_from_bytes(input logic [2:0] nbytes);
    case (nbytes)
      3'd1:    lanes_from_bytes = 4'b1000;
      3'd2:    lanes_from_bytes = 4'b1100;
      3'd3:    lanes_from_bytes = 4'b1110;
      3'd4:    lanes_from_bytes = 4'b1111;
      default: lanes_from_bytes = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/bit_aligner.sv
// rtl/bit_aligner.sv - appends an n-bit code MSB-first below the current fill
module bit_aligner
  import prores_pkg::*;
(
  input  logic [ACC_BITS-1:0] i_acc,
  input  logic [6:0]          i_fill,
  input  logic [63:0]         i_val,
  input  logic [6:0]          i_n,
  input  logic                i_en,
  output logic [ACC_BITS-1:0] o_acc,
  output logic [6:0]          o_fill
);

  logic [63:0] w_mask;
  logic [63:0] w_code;
  logic [6:0]  w_shift;

  always_comb begin
    w_mask  = (64'd1 << i_n) - 64'd1;
    w_code  = i_val & w_mask;
    // Bits below the fill are always zero, so OR-ing in the shifted code is safe.
    w_shift = 7'd64 - i_fill - i_n;
    o_acc   = i_acc;
    o_fill  = i_fill;
    if (i_en && (i_n != 7'd0)) begin
      o_acc  = i_acc | (w_code << w_shift);
      o_fill = i_fill + i_n;
    end
  end

endmodule

// File: rtl/bitstream_packer.sv
// rtl/bitstream_packer.sv - packs variable-length codes into 32-bit big-endian words
module bitstream_packer
  import prores_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int MAX_CODE_BITS = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_enable,
  input  logic [63:0]           in_val,
  input  logic [63:0]           in_size_of_bit,
  input  logic                  in_flush,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [WORD_BITS-1:0]  out_data,
  output logic [3:0]            out_byte_en,
  output logic [31:0]           byte_count,
  output logic                  busy,
  output logic                  err_size,
  output logic                  err_overrun
);

  packer_state_t         r_state;
  logic [ACC_BITS-1:0]   r_acc;
  logic [6:0]            r_fill;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;

  logic                  w_size_ok;
  logic [ACC_BITS-1:0]   w_acc;
  logic [6:0]            w_fill;
  logic [6:0]            w_fill_p7;
  logic [6:0]            w_pad;

  assign w_size_ok = (in_size_of_bit <= 64'(MAX_CODE_BITS));
  assign w_fill_p7 = w_fill + 7'd7;
  assign w_pad     = {w_fill_p7[6:3], 3'b000};
  assign busy      = (r_state == PK_DRAIN);

  bit_aligner u_aligner (
    .i_acc  (r_acc),
    .i_fill (r_fill),
    .i_val  (in_val),
    .i_n    (in_size_of_bit[6:0]),
    .i_en   (in_enable && w_size_ok),
    .o_acc  (w_acc),
    .o_fill (w_fill)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= PK_RUN;
      r_acc       <= '0;
      r_fill      <= '0;
      r_wr_ptr    <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      out_byte_en <= '0;
      byte_count  <= '0;
      err_size    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (start) begin
        r_state     <= PK_RUN;
        r_acc       <= '0;
        r_fill      <= '0;
        r_wr_ptr    <= base_addr;
        byte_count  <= '0;
        err_size    <= 1'b0;
        err_overrun <= 1'b0;
      end else if (r_state == PK_DRAIN) begin
        if (in_enable || in_flush) err_overrun <= 1'b1;
        out_valid   <= 1'b1;
        out_addr    <= r_wr_ptr;
        out_data    <= r_acc[63:32];
        out_byte_en <= lanes_from_bytes(r_fill[5:3]);
        byte_count  <= byte_count + 32'(r_fill[5:3]);
        r_wr_ptr    <= r_wr_ptr + ADDR_WIDTH'(1);
        r_acc       <= '0;
        r_fill      <= '0;
        r_state     <= PK_RUN;
      end else begin
        if (in_enable && !w_size_ok) err_size <= 1'b1;
        if (in_flush) begin
          r_acc  <= '0;
          r_fill <= '0;
          if (w_pad != 7'd0) begin
            out_valid <= 1'b1;
            out_addr  <= r_wr_ptr;
            out_data  <= w_acc[63:32];
            r_wr_ptr  <= r_wr_ptr + ADDR_WIDTH'(1);
            // More than one word of residue: the tail goes out from DRAIN.
            if (w_pad > 7'd32) begin
              out_byte_en <= 4'hF;
              byte_count  <= byte_count + 32'd4;
              r_acc       <= w_acc << 32;
              r_fill      <= w_pad - 7'd32;
              r_state     <= PK_DRAIN;
            end else begin
              out_byte_en <= lanes_from_bytes(w_pad[5:3]);
              byte_count  <= byte_count + 32'(w_pad[5:3]);
            end
          end
        end else if (w_fill >= 7'd32) begin
          out_valid   <= 1'b1;
          out_addr    <= r_wr_ptr;
          out_data    <= w_acc[63:32];
          out_byte_en <= 4'hF;
          byte_count  <= byte_count + 32'd4;
          r_wr_ptr    <= r_wr_ptr + ADDR_WIDTH'(1);
          r_acc       <= w_acc << 32;
          r_fill      <= w_fill - 7'd32;
        end else begin
          r_acc  <= w_acc;
          r_fill <= w_fill;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitstream_packer.sv
// tb/tb_bitstream_packer.sv - randomized bench with a bit-queue reference model
module tb_bitstream_packer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic        in_enable = 1'b0;
  logic [63:0] in_val = '0;
  logic [63:0] in_size_of_bit = '0;
  logic        in_flush = 1'b0;
  logic        out_valid;
  logic [15:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_byte_en;
  logic [31:0] byte_count;
  logic        busy;
  logic        err_size;
  logic        err_overrun;

  bitstream_packer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .in_enable      (in_enable),
    .in_val         (in_val),
    .in_size_of_bit (in_size_of_bit),
    .in_flush       (in_flush),
    .out_valid      (out_valid),
    .out_addr       (out_addr),
    .out_data       (out_data),
    .out_byte_en    (out_byte_en),
    .byte_count     (byte_count),
    .busy           (busy),
    .err_size       (err_size),
    .err_overrun    (err_overrun)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Reference state: pending bits in send order plus one optional queued residue word.
  bit          mq[$];
  logic [15:0] m_ptr;
  int unsigned m_count;
  bit          m_es, m_eo;
  bit          pend_valid;
  logic [31:0] pend_data;
  int          pend_nb;

  logic        e_valid;
  logic [15:0] e_addr;
  logic [31:0] e_data;
  logic [3:0]  e_be;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] take_bits(input int k);
    logic [31:0] w = '0;
    for (int i = 0; i < k; i++) w[31-i] = mq.pop_front();
    return w;
  endfunction

  function automatic void emit(input logic [31:0] w, input int nb);
    e_valid = 1'b1;
    e_addr  = m_ptr;
    e_data  = w;
    e_be    = 4'hF << (4 - nb);
    m_ptr   = m_ptr + 16'd1;
    m_count = m_count + nb;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ptr = '0; m_count = 0; m_es = 0; m_eo = 0; pend_valid = 0;
    e_valid = 0; e_addr = '0; e_data = '0; e_be = '0;
  endfunction

  function automatic void model_step(input bit st, input logic [15:0] base, input bit en,
                                     input logic [63:0] val, input logic [63:0] n, input bit fl);
    int k;
    e_valid = 1'b0;
    if (st) begin
      mq.delete();
      m_ptr = base; m_count = 0; m_es = 0; m_eo = 0; pend_valid = 0;
    end else if (pend_valid) begin
      if (en || fl) m_eo = 1;
      emit(pend_data, pend_nb);
      pend_valid = 0;
    end else begin
      if (en) begin
        if (n > 64'd32) m_es = 1;
        else for (int i = int'(n) - 1; i >= 0; i--) mq.push_back(val[i]);
      end
      if (fl) begin
        while (mq.size() % 8 != 0) mq.push_back(1'b0);
        if (mq.size() > 0) begin
          k = (mq.size() < 32) ? mq.size() : 32;
          emit(take_bits(k), k / 8);
          if (mq.size() > 0) begin
            pend_nb    = mq.size() / 8;
            pend_data  = take_bits(mq.size());
            pend_valid = 1;
          end
        end
      end else if (mq.size() >= 32) begin
        emit(take_bits(32), 4);
      end
    end
  endfunction

  always @(negedge clock) begin
    if (chk_on) begin
      chk("valid", out_valid, e_valid);
      chk("count", byte_count, m_count);
      chk("busy", busy, pend_valid);
      chk("err_size", err_size, m_es);
      chk("err_overrun", err_overrun, m_eo);
      if (e_valid) begin
        chk("addr", out_addr, e_addr);
        chk("data", out_data, e_data);
        chk("byte_en", out_byte_en, e_be);
      end
    end
  end

  task automatic step(input bit st, input logic [15:0] base, input bit en,
                      input logic [63:0] val, input logic [63:0] n, input bit fl);
    start = st; base_addr = base; in_enable = en; in_val = val;
    in_size_of_bit = n; in_flush = fl;
    @(posedge clock);
    model_step(st, base, en, val, n, fl);
    #1;
    start = 0; in_enable = 0; in_flush = 0;
  endtask

  task automatic code(input logic [63:0] val, input logic [63:0] n);
    step(0, '0, 1, val, n, 0);
  endtask

  initial begin
    model_reset();
    #1 chk_on = 1'b1;
    @(posedge clock); #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_data", out_data, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    step(1, 16'h0010, 0, 0, 0, 0);
    code(64'h5, 3); code(64'h1F, 5); code(64'hABCDEF, 24);
    chk("lit1_valid", out_valid, 1);
    chk("lit1_addr", out_addr, 16'h0010);
    chk("lit1_data", out_data, 32'hBFABCDEF);
    chk("lit1_be", out_byte_en, 4'hF);
    chk("lit1_count", byte_count, 4);

    step(1, 16'h0010, 0, 0, 0, 0);
    code(64'h3, 2);
    step(0, '0, 0, 0, 0, 1);
    chk("lit2_data", out_data, 32'hC0000000);
    chk("lit2_be", out_byte_en, 4'b1000);
    chk("lit2_count", byte_count, 1);

    step(1, 16'h0020, 0, 0, 0, 0);
    code(64'hFFFFFFF, 28);
    step(0, '0, 1, 64'hFFFFFFFF, 32, 1);
    chk("lit3_data0", out_data, 32'hFFFFFFFF);
    chk("lit3_busy0", busy, 1);
    step(0, '0, 1, 64'hAA, 8, 0);
    chk("lit3_valid1", out_valid, 1);
    chk("lit3_data1", out_data, 32'hFFFFFFF0);
    chk("lit3_addr1", out_addr, 16'h0021);
    chk("lit3_busy1", busy, 0);
    chk("lit3_count", byte_count, 8);
    chk("lit3_overrun", err_overrun, 1);
    step(0, '0, 0, 0, 0, 1);
    chk("lit3_dropped", out_valid, 0);

    step(1, 16'h0030, 0, 0, 0, 0);
    code(64'h1, 40);
    chk("lit4_err_size", err_size, 1);
    step(0, '0, 0, 0, 0, 1);
    chk("lit4_noflush", out_valid, 0);

    step(1, 16'h0040, 0, 0, 0, 0);
    code(64'hABCDE, 20);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("lit5_rst_count", byte_count, 0);
    chk("lit5_rst_addr", out_addr, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    step(0, '0, 0, 0, 0, 1);
    chk("lit5_noemit", out_valid, 0);

    step(1, 16'hFFFE, 0, 0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      bit st, en, fl;
      logic [63:0] n, v;
      st = ($urandom_range(0, 99) < 2);
      en = ($urandom_range(0, 99) < 70);
      fl = ($urandom_range(0, 99) < 8);
      n  = ($urandom_range(0, 19) == 0) ? 64'(33 + $urandom_range(0, 10))
                                         : 64'($urandom_range(0, 32));
      v  = {$urandom(), $urandom()};
      step(st, 16'($urandom()), en, v, n, fl);
    end
    step(0, '0, 0, 0, 0, 1);
    step(0, '0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);

    @(negedge clock);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
